v_shift_round_sat: RTL and testbench

Parametrised vector scaling stage for the quantised MLP datapath. Streams a vector of `InVecLength` signed elements in chunks of `WorkingRegs` lanes and applies a per-vector signed shift: right shift with optional round-half-up, or left shift. Each lane saturates to `OutBits` and the block counts saturations per vector. It replaces the fixed right-shift requantiser between MAC accumulators and the next layer's FIFO, and adds full valid/ready backpressure.

---
 rtl/v_shift_round_sat_if.sv | 33 +++
 rtl/v_shift_round_sat.sv | 171 +++++++++++++++++
 tb/tb_v_shift_round_sat.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_shift_round_sat_if.sv
// Chunk stream interface for the shift/round/saturate stage: per-vector shift controls,
// input chunk handshake and output chunk handshake with the running saturation count.
interface v_shift_round_sat_if #(
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8,
    parameter int OutBits     = 8,
    parameter int MaxShift    = 7
);
    localparam int SW   = $clog2(MaxShift + 1) + 1;
    localparam int CNTW = $clog2(InVecLength + 1);

    logic signed [SW-1:0]              shift_amt;
    logic                              round_en;
    logic                              in_valid;
    logic [WorkingRegs*NBits-1:0]      in_data;
    logic                              in_ready;
    logic                              out_valid;
    logic                              out_ready;
    logic [WorkingRegs*OutBits-1:0]    out_data;
    logic                              out_last;
    logic [CNTW-1:0]                   out_sat_count;

    modport master (
        output shift_amt, round_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat_count
    );

    modport slave (
        input  shift_amt, round_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat_count
    );
endinterface

// File: rtl/v_shift_round_sat.sv
// Per-vector signed shift (round-half-up right / left) with per-lane saturation and sat counting.
// Latency 2 cycles; two-entry skid pipeline, in_ready combinational from out_ready only.
module v_shift_round_sat #(
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8,
    parameter int OutBits     = 8,
    parameter int MaxShift    = 7
) (
    input  logic              clk_in,
    input  logic              rst_in,
    v_shift_round_sat_if.slave io
);
    localparam int Chunks = InVecLength / WorkingRegs;
    localparam int SW     = $clog2(MaxShift + 1) + 1;
    localparam int LW     = NBits + MaxShift;
    localparam int CW     = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int PW     = $clog2(WorkingRegs + 1);
    localparam int CNTW   = $clog2(InVecLength + 1);

    localparam logic [CW-1:0]        LastIdx = CW'(Chunks - 1);
    localparam logic signed [SW-1:0] KMax    = SW'(MaxShift);
    localparam logic signed [LW-1:0] SatMax  = LW'((1 << (OutBits - 1)) - 1);
    localparam logic signed [LW-1:0] SatMin  = ~SatMax;

    logic [CW-1:0]                    in_idx_q, in_idx_d;
    logic signed [SW-1:0]             k_q, k_d;
    logic                             rnd_q, rnd_d;
    logic                             s1_vld_q, s1_vld_d;
    logic                             s1_last_q, s1_last_d;
    logic signed [LW-1:0]             s1_lane_q [WorkingRegs];
    logic signed [LW-1:0]             s1_lane_d [WorkingRegs];
    logic                             s2_vld_q, s2_vld_d;
    logic                             s2_last_q, s2_last_d;
    logic [WorkingRegs*OutBits-1:0]   s2_dat_q, s2_dat_d;
    logic [PW-1:0]                    s2_pop_q, s2_pop_d;
    logic [CNTW-1:0]                  acc_q, acc_d;

    logic                             in_fire, out_fire, s1_load, s1_move, s2_load;
    logic                             chunk_first, chunk_last, rnd_cur;
    logic signed [SW-1:0]             k_clamp, k_cur;
    logic [SW-1:0]                    k_mag;
    logic [CNTW-1:0]                  out_count;
    logic signed [NBits-1:0]          lane_x;
    logic signed [NBits:0]            round_c, biased, rsh;

    assign io.in_ready      = ~rst_in & (~s1_vld_q | ~s2_vld_q | io.out_ready);
    assign io.out_valid     = s2_vld_q;
    assign io.out_data      = s2_dat_q;
    assign io.out_last      = s2_last_q;
    assign io.out_sat_count = out_count;

    always_comb begin : ctrl
        out_fire    = s2_vld_q & io.out_ready;
        s2_load     = ~s2_vld_q | io.out_ready;
        s1_move     = s1_vld_q & s2_load;
        s1_load     = ~s1_vld_q | s1_move;
        in_fire     = io.in_valid & io.in_ready;
        chunk_first = (in_idx_q == '0);
        chunk_last  = (in_idx_q == LastIdx);

        k_clamp = io.shift_amt;
        if (io.shift_amt > KMax) begin
            k_clamp = KMax;
        end else if (io.shift_amt < -KMax) begin
            k_clamp = -KMax;
        end
        // Chunk 0 uses the live controls; later chunks reuse what chunk 0 latched.
        k_cur   = chunk_first ? k_clamp : k_q;
        rnd_cur = chunk_first ? io.round_en : rnd_q;
        k_mag   = k_cur[SW-1] ? -k_cur : k_cur;

        in_idx_d = in_idx_q;
        k_d      = k_q;
        rnd_d    = rnd_q;
        if (in_fire) begin
            in_idx_d = chunk_last ? '0 : in_idx_q + CW'(1);
            if (chunk_first) begin
                k_d   = k_clamp;
                rnd_d = io.round_en;
            end
        end

        s1_vld_d  = s1_load ? io.in_valid : s1_vld_q;
        s1_last_d = chunk_last;
        s2_vld_d  = s2_load ? s1_vld_q : s2_vld_q;
        s2_last_d = s1_last_q;

        out_count = acc_q + CNTW'(s2_pop_q);
        acc_d     = acc_q;
        if (out_fire) begin
            acc_d = s2_last_q ? '0 : out_count;
        end
    end

    always_comb begin : shift_lanes
        lane_x  = '0;
        round_c = '0;
        biased  = '0;
        rsh     = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            lane_x  = $signed(io.in_data[i*NBits +: NBits]);
            round_c = '0;
            if (rnd_cur) begin
                round_c = (NBits + 1)'(1) << (k_mag - SW'(1));
            end
            biased = (NBits + 1)'(lane_x) + round_c;
            rsh    = biased >>> k_mag;
            if (k_cur > 0) begin
                s1_lane_d[i] = LW'(rsh);
            end else if (k_cur < 0) begin
                s1_lane_d[i] = LW'(lane_x) <<< k_mag;
            end else begin
                s1_lane_d[i] = LW'(lane_x);
            end
        end
    end

    always_comb begin : saturate
        s2_dat_d = '0;
        s2_pop_d = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            if (s1_lane_q[i] > SatMax) begin
                s2_dat_d[i*OutBits +: OutBits] = SatMax[OutBits-1:0];
                s2_pop_d = s2_pop_d + PW'(1);
            end else if (s1_lane_q[i] < SatMin) begin
                s2_dat_d[i*OutBits +: OutBits] = SatMin[OutBits-1:0];
                s2_pop_d = s2_pop_d + PW'(1);
            end else begin
                s2_dat_d[i*OutBits +: OutBits] = s1_lane_q[i][OutBits-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            in_idx_q  <= '0;
            k_q       <= '0;
            rnd_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            for (int i = 0; i < WorkingRegs; i++) begin
                s1_lane_q[i] <= '0;
            end
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_dat_q  <= '0;
            s2_pop_q  <= '0;
            acc_q     <= '0;
        end else begin
            in_idx_q <= in_idx_d;
            k_q      <= k_d;
            rnd_q    <= rnd_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            acc_q    <= acc_d;
            if (in_fire) begin
                s1_last_q <= s1_last_d;
                for (int i = 0; i < WorkingRegs; i++) begin
                    s1_lane_q[i] <= s1_lane_d[i];
                end
            end
            // Stage 2 payload only moves with a real chunk so held outputs stay stable.
            if (s1_move) begin
                s2_last_q <= s2_last_d;
                s2_dat_q  <= s2_dat_d;
                s2_pop_q  <= s2_pop_d;
            end
        end
    end
endmodule

// File: tb/tb_v_shift_round_sat.sv
// Scoreboard bench for v_shift_round_sat: directed test-plan vectors, backpressure, mid-vector
// reset and randomized traffic checked against an arithmetic reference model.
module tb_v_shift_round_sat;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    v_shift_round_sat_if #(.InVecLength(8), .WorkingRegs(4), .NBits(8), .OutBits(8), .MaxShift(7)) io ();

    v_shift_round_sat #(.InVecLength(8), .WorkingRegs(4), .NBits(8), .OutBits(8), .MaxShift(7)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .io     (io)
    );

    typedef struct {
        logic [31:0] d;
        bit          last;
        int          cnt;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_edge = 0;
    int rdy_mode = 0;
    int m_idx = 0;
    int m_k = 0;
    int m_acc = 0;
    bit m_rnd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int lane_ref(input int x, input int k, input bit rnd);
        int n, dv, q;
        if (k > 0) begin
            n  = x + (rnd ? 2 ** (k - 1) : 0);
            dv = 2 ** k;
            q  = n / dv;
            if ((n % dv != 0) && (n < 0)) q = q - 1;
            return q;
        end else if (k < 0) begin
            return x * (2 ** (-k));
        end
        return x;
    endfunction

    function automatic exp_t model_step(input logic [31:0] dat, input int shamt, input bit rnd);
        exp_t e;
        int x, y, pop;
        if (m_idx == 0) begin
            m_k   = (shamt > 7) ? 7 : (shamt < -7) ? -7 : shamt;
            m_rnd = rnd;
        end
        pop = 0;
        e.d = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(dat[i*8 +: 8]));
            y = lane_ref(x, m_k, m_rnd);
            if (y > 127) begin
                y = 127;
                pop++;
            end else if (y < -128) begin
                y = -128;
                pop++;
            end
            e.d[i*8 +: 8] = y[7:0];
        end
        m_acc  = m_acc + pop;
        e.cnt  = m_acc;
        e.last = (m_idx == NCH - 1);
        if (e.last) begin
            m_acc = 0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] dat, input int shamt, input bit rnd,
                        input bit use_exp, input logic [31:0] ed, input bit el, input int ec);
        int w;
        exp_t e;
        @(negedge clk);
        io.in_valid  = 1'b1;
        io.in_data   = dat;
        io.shift_amt = 4'(shamt);
        io.round_en  = rnd;
        #1;
        w = 0;
        while (!io.in_ready) begin
            if (w >= 300) begin
                errors++;
                checks++;
                $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
                io.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            w++;
        end
        e = model_step(dat, shamt, rnd);
        if (use_exp) begin
            e.d    = ed;
            e.last = el;
            e.cnt  = ec;
        end
        sbq.push_back(e);
        acc_cnt++;
        acc_edge = cyc;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic sendx(input logic [31:0] dat, input int shamt, input bit rnd,
                         input logic [31:0] ed, input bit el, input int ec);
        send(dat, shamt, rnd, 1'b1, ed, el, ec);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, io.out_valid, 0);
        chk({tag, "_out_last"}, io.out_last, 0);
        chk({tag, "_out_data"}, io.out_data, 0);
        chk({tag, "_out_sat_count"}, io.out_sat_count, 0);
        chk({tag, "_in_ready"}, io.in_ready, 0);
    endtask

    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            io.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom % 4 != 0);
        end
    end

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && io.out_valid && io.out_ready) begin
            if (sbq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_output: data=%0h with empty scoreboard", io.out_data);
            end else begin
                e = sbq.pop_front();
                chk("out_data", io.out_data, e.d);
                chk("out_last", io.out_last, e.last);
                chk("out_sat_count", io.out_sat_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, snap;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.shift_amt = '0;
        io.round_en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Rounding, plus first-chunk latency from an idle pipeline
        sendx(pk(7, -7, 6, -6), 2, 1, pk(2, -2, 2, -1), 0, 0);
        w = 0;
        do begin
            @(negedge clk);
            #2;
            w++;
        end while (!io.out_valid && w < 20);
        chk("latency_cycles", cyc - acc_edge, 2);
        sendx(pk(7, -7, 6, -6), 2, 0, pk(2, -2, 2, -1), 1, 0);
        sendx(pk(7, -7, 6, -6), 2, 0, pk(1, -2, 1, -2), 0, 0);
        sendx(pk(0, 0, 0, 0), 2, 1, pk(0, 0, 0, 0), 1, 0);

        // Left-shift saturation
        sendx(pk(10, -20, 16, -16), -3, 0, pk(80, -128, 127, -128), 0, 2);
        sendx(pk(1, 1, 1, 1), -3, 0, pk(8, 8, 8, 8), 1, 2);

        // Per-vector shift, mid-vector shift_amt changes ignored
        sendx(pk(10, -10, 3, -3), 1, 0, pk(5, -5, 1, -2), 0, 0);
        sendx(pk(100, -100, 1, 2), 5, 0, pk(50, -50, 0, 1), 1, 0);
        sendx(pk(100, -100, 20, -64), -1, 0, pk(127, -128, 40, -128), 0, 2);
        sendx(pk(1, -1, 63, 64), 3, 0, pk(2, -2, 126, 127), 1, 3);

        // Most negative representable shift clamps to -7; zero shift ignores rounding
        sendx(pk(1, 0, -1, 2), -8, 0, pk(127, 0, -128, 127), 0, 2);
        sendx(pk(0, 0, 0, 0), -8, 0, pk(0, 0, 0, 0), 1, 2);
        sendx(pk(-5, 5, 127, -128), 0, 1, pk(-5, 5, 127, -128), 0, 0);
        sendx(pk(-1, 1, 0, 0), 0, 1, pk(-1, 1, 0, 0), 1, 0);
        drain();

        // Backpressure: downstream stalled while 4 chunks are offered
        rdy_mode = 2;
        @(negedge clk);
        snap = acc_cnt;
        fork
            begin
                for (int c = 0; c < 4; c++) begin
                    send($urandom, 1, 1'b1, 1'b0, '0, 1'b0, 0);
                end
            end
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    #2;
                    w++;
                end while (!io.out_valid && w < 20);
                repeat (5) begin
                    @(negedge clk);
                    #2;
                    chk("stall_out_valid", io.out_valid, 1);
                    chk("stall_out_data", io.out_data, sbq[0].d);
                    chk("stall_out_last", io.out_last, sbq[0].last);
                end
                chk("stall_in_ready", io.in_ready, 0);
                chk("stall_accepted", acc_cnt - snap, 2);
                rdy_mode = 0;
            end
        join
        drain();

        // Reset mid-vector after chunk 0 delivered with saturations
        sendx(pk(16, -17, 1, 0), -3, 0, pk(127, -128, 8, 0), 0, 2);
        drain();
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        m_idx = 0;
        m_acc = 0;
        @(negedge clk);
        #2;
        check_reset_state("midreset");
        @(negedge clk);
        rst = 1'b0;
        sendx(pk(1, 2, 3, 4), 0, 0, pk(1, 2, 3, 4), 0, 0);
        sendx(pk(5, 6, 7, 8), 4, 1, pk(5, 6, 7, 8), 1, 0);
        drain();

        // Randomized traffic with random downstream stalls
        rdy_mode = 1;
        for (int v = 0; v < 40; v++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom % 3 == 0) @(negedge clk);
                send($urandom, int'($urandom_range(0, 15)) - 8, 1'($urandom % 2), 1'b0, '0, 1'b0, 0);
            end
        end
        drain();
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
